sprite_blitter: RTL and testbench



---
 rtl/sprite_blitter.sv | 134 +++++++++++++
 tb/tb_sprite_blitter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a SPR_W x SPR_H palette sprite from a sync ROM into
// the frame buffer at (pos_x, pos_y), skipping transparent pixels and clipping.
module sprite_blitter #(
    parameter int               FB_W        = 640,
    parameter int               FB_H        = 480,
    parameter int               SPR_W       = 32,
    parameter int               SPR_H       = 32,
    parameter int               IDX_W       = 4,
    parameter logic [IDX_W-1:0] TRANSPARENT = '0
) (
    input  logic                               Clk,
    input  logic                               Reset_n,
    input  logic                               start,
    input  logic [9:0]                         pos_x,
    input  logic [8:0]                         pos_y,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(SPR_W*SPR_H)-1:0]     rom_addr,
    input  logic [IDX_W-1:0]                   rom_q,
    output logic                               fb_we,
    output logic [18:0]                        fb_addr,
    output logic [IDX_W-1:0]                   fb_data
);

    localparam int          XW    = $clog2(SPR_W);
    localparam int          YW    = $clog2(SPR_H);
    localparam logic [10:0] FB_WL = 11'(FB_W);
    localparam logic [10:0] FB_HL = 11'(FB_H);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    logic [9:0]    px_q;
    logic [8:0]    py_q;
    logic          accept;
    logic          last_pix;

    logic          s1_valid;
    logic [10:0]   tx;
    logic [10:0]   ty;
    logic          wr;

    assign accept   = start && (state == IDLE || state == DONE);
    assign last_pix = (&sx) && (&sy);
    assign rom_addr = {sy, sx};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_pix) state_nxt = DRAIN;
            DRAIN:   if (!s1_valid) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN, DRAIN: busy = 1'b1;
            DONE:       done = 1'b1;
            default:    ;
        endcase
    end

    // Raster scan counters; power-of-2 sizes let sx/sy wrap naturally
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sx   <= '0;
            sy   <= '0;
            px_q <= '0;
            py_q <= '0;
        end else if (accept) begin
            sx   <= '0;
            sy   <= '0;
            px_q <= pos_x;
            py_q <= pos_y;
        end else if (state == RUN) begin
            sx <= sx + 1'b1;
            if (&sx) begin
                sy <= sy + 1'b1;
            end
        end
    end

    // Stage 1 lines the screen coordinates up with the ROM's one-cycle latency
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            tx       <= '0;
            ty       <= '0;
        end else begin
            s1_valid <= (state == RUN);
            tx       <= 11'({1'b0, px_q}) + 11'(sx);
            ty       <= 11'({2'b0, py_q}) + 11'(sy);
        end
    end

    assign wr = s1_valid && (rom_q != TRANSPARENT) && (tx < FB_WL) && (ty < FB_HL);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= '0;
        end else begin
            fb_we <= wr;
            if (wr) begin
                fb_addr <= 19'(ty) * 19'(FB_W) + 19'(tx);
                fb_data <= rom_q;
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: table of blits plus reset and
// handshake sequences, checked against a per-pixel reference of the blit.
module tb_sprite_blitter;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  pos_x = '0;
    logic [8:0]  pos_y = '0;
    logic        busy;
    logic        done;
    logic [9:0]  rom_addr;
    logic [3:0]  rom_q;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [3:0]  fb_data;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] rom_mem [1024];
    int got_a[$];
    int got_d[$];
    int exp_a[$];
    int exp_d[$];

    sprite_blitter dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_q <= rom_mem[rom_addr];

    always @(negedge Clk) begin
        if (fb_we === 1'b1) begin
            got_a.push_back(int'(fb_addr));
            got_d.push_back(int'(fb_data));
        end
    end

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic void fill_rom(input int pat);
        for (int a = 0; a < 1024; a++) begin
            case (pat)
                0:       rom_mem[a] = 4'((a % 15) + 1);
                1:       rom_mem[a] = (((a % 32) + (a / 32)) % 2 == 1) ? 4'h0 : 4'h7;
                2:       rom_mem[a] = 4'($urandom_range(1, 15));
                default: rom_mem[a] = 4'($urandom_range(0, 15));
            endcase
        end
    endfunction

    // Expected write list: every opaque on-screen pixel, in sprite raster order
    function automatic void build_model(input int px, input int py);
        exp_a.delete();
        exp_d.delete();
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 32; x++) begin
                int v;
                v = int'(rom_mem[y * 32 + x]);
                if (v != 0 && px + x < 640 && py + y < 480) begin
                    exp_a.push_back((py + y) * 640 + px + x);
                    exp_d.push_back(v);
                end
            end
        end
    endfunction

    task automatic issue(input int px, input int py);
        start = 1'b1;
        pos_x = 10'(px);
        pos_y = 9'(py);
        @(posedge Clk);
        #1 start = 1'b0;
    endtask

    task automatic watch(input int ignore_at, input bit chain, input int cpx,
                         input int cpy, output int done_cyc);
        done_cyc = -1;
        for (int c = 1; c <= 1100; c++) begin
            @(negedge Clk);
            if (c == 1) chk("busy_rise", int'(busy), 1);
            if (ignore_at != 0 && c == ignore_at) begin
                start = 1'b1;
                pos_x = 10'd300;
                pos_y = 9'd300;
            end
            if (ignore_at != 0 && c == ignore_at + 1) start = 1'b0;
            if (done === 1'b1) begin
                done_cyc = c;
                chk("busy_at_done", int'(busy), 0);
                if (chain) begin
                    start = 1'b1;
                    pos_x = 10'(cpx);
                    pos_y = 9'(cpy);
                end
                break;
            end
        end
    endtask

    task automatic compare_list(input string tag);
        int bad;
        int n;
        bad = 0;
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        chk({tag, "_count"}, got_a.size(), exp_a.size());
        for (int i = 0; i < n; i++) begin
            if (got_a[i] != exp_a[i] || got_d[i] != exp_d[i]) begin
                if (bad == 0)
                    $display("FAIL %s_first_diff idx %0d: got %0d/%0d, expected %0d/%0d",
                             tag, i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
                bad++;
            end
        end
        chk({tag, "_wlist_bad"}, bad, 0);
    endtask

    typedef struct {
        int px;
        int py;
        int pat;
        int exp_n;
        int exp_first;
        int exp_max;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int dc;
        int mx;

        tbl[0] = '{0,   0,   0, 1024, 0,      19871};
        tbl[1] = '{100, 50,  1, 512,  32100,  51971};
        tbl[2] = '{620, 470, 2, 200,  301420, 307199};
        tbl[3] = '{639, 479, 2, 1,    307199, 307199};
        for (int i = 4; i < 8; i++) begin
            tbl[i] = '{int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                       3, -1, -1, -1};
        end

        fill_rom(0);
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            start = 1'($urandom_range(0, 1));
            pos_x = 10'($urandom_range(0, 1023));
            pos_y = 9'($urandom_range(0, 511));
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_fb_we", int'(fb_we), 0);
            chk("rst_fb_addr", int'(fb_addr), 0);
            chk("rst_fb_data", int'(fb_data), 0);
            chk("rst_rom_addr", int'(rom_addr), 0);
        end
        @(negedge Clk);
        start = 1'b0;
        Reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge Clk);
            chk("idle_quiet", int'(busy | fb_we | done), 0);
        end

        foreach (tbl[i]) begin
            fill_rom(tbl[i].pat);
            build_model(tbl[i].px, tbl[i].py);
            got_a.delete();
            got_d.delete();
            @(negedge Clk);
            issue(tbl[i].px, tbl[i].py);
            watch(0, 1'b0, 0, 0, dc);
            chk("done_cycle", dc, 1027);
            compare_list("blit");
            if (tbl[i].exp_n >= 0) begin
                mx = -1;
                foreach (got_a[k]) if (got_a[k] > mx) mx = got_a[k];
                chk("tbl_count", got_a.size(), tbl[i].exp_n);
                chk("tbl_first_addr", (got_a.size() > 0) ? got_a[0] : -1, tbl[i].exp_first);
                chk("tbl_max_addr", mx, tbl[i].exp_max);
            end
        end

        // start mid-blit is dropped; start in the done cycle chains a new blit
        fill_rom(0);
        build_model(0, 0);
        got_a.delete();
        got_d.delete();
        @(negedge Clk);
        issue(0, 0);
        watch(500, 1'b1, 8, 8, dc);
        chk("hs_done_cycle", dc, 1027);
        compare_list("hs_first");
        build_model(8, 8);
        got_a.delete();
        got_d.delete();
        @(posedge Clk);
        #1 start = 1'b0;
        watch(0, 1'b0, 0, 0, dc);
        chk("chain_done_cycle", dc, 1027);
        chk("chain_first_addr", (got_a.size() > 0) ? got_a[0] : -1, 5128);
        compare_list("chain");

        // reset in the middle of a blit
        fill_rom(3);
        @(negedge Clk);
        issue(0, 0);
        for (int c = 1; c <= 300; c++) @(negedge Clk);
        Reset_n = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            chk("midrst_fb_we", int'(fb_we), 0);
            chk("midrst_busy", int'(busy), 0);
            chk("midrst_done", int'(done), 0);
        end
        Reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            chk("post_rst_quiet", int'(busy | fb_we | done), 0);
        end
        fill_rom(0);
        build_model(0, 0);
        got_a.delete();
        got_d.delete();
        issue(0, 0);
        watch(0, 1'b0, 0, 0, dc);
        chk("post_rst_done_cycle", dc, 1027);
        compare_list("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
